// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory controller: word width, parameter
// defaults and the access FSM state encoding.
package lc3_pkg;

  localparam int LC3_WORD_W      = 16;
  localparam int LC3_ADDR_W_DEF  = 7;
  localparam int LC3_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lc3_state_e;

endpackage

// File: rtl/lc3_wait_timer.sv
// Counts consecutive WAIT cycles; expired marks the TIMEOUT-th WAIT cycle.
module lc3_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter restarts whenever the FSM is outside WAIT.
  always_comb begin
    cnt_d = en ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: accepts one CPU load/store at a time, issues a
// single-cycle registered strobe, waits for mem_ready (with timeout) and responds.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = LC3_ADDR_W_DEF,
  parameter int TIMEOUT = LC3_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [LC3_WORD_W-1:0] req_mar,
  input  logic [LC3_WORD_W-1:0] req_mdr,
  output logic                  rsp_valid,
  output logic [LC3_WORD_W-1:0] rsp_mdr,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic [LC3_WORD_W-1:0] mem_d,
  input  logic [LC3_WORD_W-1:0] mem_dout,
  input  logic                  mem_ready
);

  lc3_state_e            state_q, state_d;
  logic                  write_q, write_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]     mem_waddr_q, mem_waddr_d;
  logic [ADDR_W-1:0]     mem_raddr_q, mem_raddr_d;
  logic [LC3_WORD_W-1:0] mem_d_q, mem_d_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [LC3_WORD_W-1:0] rsp_mdr_q, rsp_mdr_d;
  logic                  accept;
  logic                  in_range;
  logic                  timer_expired;

  lc3_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_WAIT),
    .expired (timer_expired)
  );

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign in_range = (req_mar >> ADDR_W) == '0;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_raddr_d = mem_raddr_q;
    mem_d_d     = mem_d_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_mdr_d   = rsp_mdr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          if (in_range) begin
            // Strobe and address registers load at acceptance so they are live in STROBE.
            state_d     = ST_STROBE;
            mem_we_d    = req_write;
            mem_re_d    = !req_write;
            mem_waddr_d = req_mar[ADDR_W-1:0];
            mem_raddr_d = req_mar[ADDR_W-1:0];
            mem_d_d     = req_mdr;
          end else begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready) begin
          if (!write_q) rsp_mdr_d = mem_dout;
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
        end else if (timer_expired) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mdr_q   <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_waddr_q <= mem_waddr_d;
      mem_raddr_q <= mem_raddr_d;
      mem_d_q     <= mem_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mdr_q   <= rsp_mdr_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_mdr   = rsp_mdr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_d     = mem_d_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with a behavioural memory and a response scoreboard.
module tb_lc3_mem_ctrl;
  import lc3_pkg::*;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_mar = 16'h0000;
  logic [15:0] req_mdr = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_mdr;
  logic        rsp_err;
  logic        mem_we, mem_re;
  logic [6:0]  mem_waddr, mem_raddr;
  logic [15:0] mem_d;
  logic [15:0] mem_dout = 16'h0000;
  logic        mem_ready = 1'b0;

  lc3_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mar(req_mar), .req_mdr(req_mdr),
    .rsp_valid(rsp_valid), .rsp_mdr(rsp_mdr), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_d(mem_d), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory: write ready one cycle after the strobe, read data/ready two cycles after.
  logic [15:0] mem [0:127];
  logic        rd_pend = 1'b0;
  logic [6:0]  rd_addr = 7'd0;
  logic        stall = 1'b0;
  logic        pre_en = 1'b0;
  logic [6:0]  pre_addr = 7'd0;
  logic [15:0] pre_data = 16'h0000;

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    rd_pend   <= 1'b0;
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_we) begin
      mem[mem_waddr] <= mem_d;
      mem_ready      <= !stall;
    end
    if (mem_re) begin
      rd_pend <= 1'b1;
      rd_addr <= mem_raddr;
    end
    if (rd_pend) begin
      mem_ready <= !stall;
      mem_dout  <= mem[rd_addr];
    end
  end

  typedef struct packed {
    logic        err;
    logic [15:0] mdr;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [0:127];
  logic [15:0] model_mdr = 16'h0000;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic w, input logic [15:0] mar, input logic [15:0] mdr);
    exp_t e;
    if ((mar >> ADDR_W) != 16'h0) begin
      e = '{err: 1'b1, mdr: model_mdr, lat: 8'd1};
    end else if (w) begin
      ref_mem[mar[6:0]] = mdr;
      e = '{err: 1'b0, mdr: model_mdr, lat: 8'd3};
    end else if (stall) begin
      e = '{err: 1'b1, mdr: model_mdr, lat: 8'(2 + TIMEOUT)};
    end else begin
      model_mdr = ref_mem[mar[6:0]];
      e = '{err: 1'b0, mdr: model_mdr, lat: 8'd4};
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [15:0] mar, input logic [15:0] mdr,
                       input logic hold, input logic track);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_write = w;
    req_mar   = mar;
    req_mdr   = mdr;
    if (track) push_exp(w, mar, mdr);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_write = ~w;
      req_mar   = 16'hFFFF;
      req_mdr   = 16'hDEAD;
    end
  endtask

  task automatic wait_rsp(input string tag, output int n_we, output int n_re, output int sk,
                          output logic [6:0] saddr, output logic [15:0] sdata);
    logic got;
    exp_t e;
    got = 1'b0; n_we = 0; n_re = 0; sk = 0; saddr = '0; sdata = '0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (mem_we) begin n_we++; sk = k; saddr = mem_waddr; sdata = mem_d; end
      if (mem_re) begin n_re++; sk = k; saddr = mem_raddr; end
      if (rsp_valid) begin
        got = 1'b1;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
          check({tag, "_mdr"}, 32'(rsp_mdr), 32'(e.mdr));
          check({tag, "_lat"}, 32'(k), 32'(e.lat));
        end
      end
    end
    check({tag, "_rsp_seen"}, 32'(got), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int nw, nr, sk, sk2, cnt;
    logic [6:0] sa;
    logic [15:0] sd;

    // Reset state and memory preload.
    pre_en = 1'b1; pre_addr = 7'h7F; pre_data = 16'h1234;
    ref_mem[7'h7F] = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    pre_en = 1'b0;
    check("rst_we", 32'(mem_we), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_waddr", 32'(mem_waddr), 0);
    check("rst_raddr", 32'(mem_raddr), 0);
    check("rst_d", 32'(mem_d), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_mdr", 32'(rsp_mdr), 0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", 32'(req_ready), 1);

    // Store 0xBEEF to 0x0005.
    issue(1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b1);
    wait_rsp("st5", nw, nr, sk, sa, sd);
    check("st5_nwe", 32'(nw), 1);
    check("st5_nre", 32'(nr), 0);
    check("st5_k", 32'(sk), 1);
    check("st5_waddr", 32'(sa), 32'h05);
    check("st5_data", 32'(sd), 32'hBEEF);
    @(negedge clk);
    check("st5_valid_1cyc", 32'(rsp_valid), 0);

    // Load of preloaded 0x7F.
    issue(1'b0, 16'h007F, 16'h0000, 1'b0, 1'b1);
    wait_rsp("ld7f", nw, nr, sk, sa, sd);
    check("ld7f_nre", 32'(nr), 1);
    check("ld7f_nwe", 32'(nw), 0);
    check("ld7f_raddr", 32'(sa), 32'h7F);

    // Read back the store.
    issue(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1);
    wait_rsp("ld5", nw, nr, sk, sa, sd);
    check("ld5_raddr", 32'(sa), 32'h05);

    // Out-of-range load: no strobe, rsp_mdr held.
    issue(1'b0, 16'h0080, 16'h0000, 1'b0, 1'b1);
    wait_rsp("oor", nw, nr, sk, sa, sd);
    check("oor_strobes", 32'(nw + nr), 0);

    // Back-to-back: req_valid held, fields switch to a load after store acceptance.
    issue(1'b1, 16'h0010, 16'hCAFE, 1'b1, 1'b1);
    req_write = 1'b0;
    req_mar   = 16'h0010;
    req_mdr   = 16'h1111;
    push_exp(1'b0, 16'h0010, 16'h1111);
    wait_rsp("b2b_st", nw, nr, sk, sa, sd);
    check("b2b_st_nwe", 32'(nw), 1);
    check("b2b_st_data", 32'(sd), 32'hCAFE);
    check("b2b_st_ready_done", 32'(req_ready), 0);
    @(negedge clk);
    check("b2b_idle_ready", 32'(req_ready), 1);
    check("b2b_idle_strobe", 32'(mem_we | mem_re), 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp("b2b_ld", nw, nr, sk2, sa, sd);
    check("b2b_ld_nre", 32'(nr), 1);
    check("b2b_ld_raddr", 32'(sa), 32'h10);
    check("b2b_gap", 32'((4 + sk2 - sk) >= 2), 1);

    // Timeout with memory never ready.
    stall = 1'b1;
    issue(1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1);
    wait_rsp("tmo", nw, nr, sk, sa, sd);
    @(negedge clk);
    check("tmo_ready_after", 32'(req_ready), 1);
    stall = 1'b0;

    // Asynchronous reset during the STROBE cycle.
    issue(1'b0, 16'h007F, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("rsts_re_before", 32'(mem_re), 1);
    rst = 1'b1;
    #1;
    check("rsts_re_async", 32'(mem_re), 0);
    check("rsts_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rsts_ready", 32'(req_ready), 1);
    check("rsts_mdr_clr", 32'(rsp_mdr), 0);
    model_mdr = 16'h0000;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_re) cnt++;
    end
    check("rsts_quiet", 32'(cnt), 0);

    // Reset while a load sits in WAIT.
    stall = 1'b1;
    issue(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_strobes", 32'(mem_we | mem_re), 0);
    check("rstw_valid", 32'(rsp_valid), 0);
    check("rstw_idle", 32'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    #1;
    check("rstw_ready", 32'(req_ready), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("rstw_no_rsp", 32'(cnt), 0);

    // Recovery: normal load after reset.
    issue(1'b0, 16'h007F, 16'h0000, 1'b0, 1'b1);
    wait_rsp("ld7f_post", nw, nr, sk, sa, sd);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
